// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: PC register, cache request, 4-deep {pc, inst} queue to the decoder.
// Fetching halts on an invalid cache word until the back end redirects.
`ifndef Inst_Addr_Width
`define Inst_Addr_Width 32
`endif
`ifndef Inst_Width
`define Inst_Width 32
`endif

module inst_fetch_unit (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        ce,
  output logic [`Inst_Addr_Width-1:0] addr,
  output logic                        pc_cache_stall,
  input  logic [`Inst_Width-1:0]      inst,
  input  logic                        cache_enable,
  input  logic                        redirect,
  input  logic [`Inst_Addr_Width-1:0] redirect_pc,
  input  logic                        dec_ready,
  output logic                        dec_valid,
  output logic [`Inst_Width-1:0]      dec_inst,
  output logic [`Inst_Addr_Width-1:0] dec_pc
);

  localparam int unsigned AW    = `Inst_Addr_Width;
  localparam int unsigned IW    = `Inst_Width;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned CNT_W = 3;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HALT  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      pc_q, pc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]      pc_mem_q [DEPTH];
  logic [AW-1:0]      pc_mem_d [DEPTH];
  logic [IW-1:0]      inst_mem_q [DEPTH];
  logic [IW-1:0]      inst_mem_d [DEPTH];

  logic fetch_slot;
  logic push;
  logic pop;
  logic not_empty;

  assign ce             = ~rst;
  assign addr           = pc_q;
  assign pc_cache_stall = (count_q == CNT_W'(DEPTH)) || (state_q == S_HALT) || redirect;
  assign fetch_slot     = ce & ~pc_cache_stall;
  assign push           = fetch_slot & cache_enable;
  assign not_empty      = (count_q != '0);
  assign dec_valid      = not_empty & ~redirect;
  assign pop            = dec_valid & dec_ready;
  assign dec_inst       = not_empty ? inst_mem_q[rd_ptr_q] : '0;
  assign dec_pc         = not_empty ? pc_mem_q[rd_ptr_q]   : '0;

  // Next-state: redirect flushes and overrides every other event.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;

    if (redirect) begin
      state_d  = S_FETCH;
      pc_d     = redirect_pc & ~AW'(3);
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]   = pc_q;
        inst_mem_d[wr_ptr_q] = inst;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        pc_d                 = pc_q + AW'(4);
      end
      if (fetch_slot && !cache_enable && state_q == S_FETCH) begin
        state_d = S_HALT;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pc_mem_q   <= pc_mem_d;
      inst_mem_q <= inst_mem_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios then random traffic against a queue-based model.
`ifndef Inst_Addr_Width
`define Inst_Addr_Width 32
`endif
`ifndef Inst_Width
`define Inst_Width 32
`endif

module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] addr;
  logic        pc_cache_stall;
  logic [31:0] inst;
  logic        cache_enable;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        cen_drv;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  bit          m_halt;

  always #5 clk = ~clk;

  // Cache content is a fixed hash of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign inst         = mem_word(addr);
  assign cache_enable = cen_drv;

  inst_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .ce             (ce),
    .addr           (addr),
    .pc_cache_stall (pc_cache_stall),
    .inst           (inst),
    .cache_enable   (cache_enable),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .dec_ready      (dec_ready),
    .dec_valid      (dec_valid),
    .dec_inst       (dec_inst),
    .dec_pc         (dec_pc)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, compare outputs with the model, then advance the model.
  task automatic step(input logic rd, input logic [31:0] rpc, input logic rdy, input logic cen);
    bit          exp_stall;
    bit          exp_valid;
    ent_t        e;
    redirect    = rd;
    redirect_pc = rpc;
    dec_ready   = rdy;
    cen_drv     = cen;
    #1;
    exp_stall = (m_q.size() == 4) || m_halt || rd;
    exp_valid = (m_q.size() != 0) && !rd;
    check_eq("ce", 32'(ce), 32'd1);
    check_eq("addr", addr, m_pc);
    check_eq("stall", 32'(pc_cache_stall), 32'(exp_stall));
    check_eq("dec_valid", 32'(dec_valid), 32'(exp_valid));
    check_eq("dec_pc", dec_pc, (m_q.size() != 0) ? m_q[0].pc : 32'd0);
    check_eq("dec_inst", dec_inst, (m_q.size() != 0) ? m_q[0].word : 32'd0);
    if (rd) begin
      m_q.delete();
      m_pc   = {rpc[31:2], 2'b00};
      m_halt = 0;
    end else begin
      if (exp_valid && rdy) void'(m_q.pop_front());
      if (!exp_stall && cen) begin
        e.pc   = m_pc;
        e.word = mem_word(m_pc);
        m_q.push_back(e);
        m_pc = m_pc + 32'd4;
      end else if (!exp_stall && !cen) begin
        m_halt = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    dec_ready   = 1'b0;
    cen_drv     = 1'b1;
    m_pc        = '0;
    m_halt      = 0;
    #3;
    check_eq("rst_ce", 32'(ce), 32'd0);
    check_eq("rst_addr", addr, 32'd0);
    check_eq("rst_valid", 32'(dec_valid), 32'd0);
    check_eq("rst_dec_pc", dec_pc, 32'd0);
    check_eq("rst_dec_inst", dec_inst, 32'd0);
    check_eq("rst_stall", 32'(pc_cache_stall), 32'd0);
    redirect = 1'b1;
    #1;
    check_eq("rst_stall_redir", 32'(pc_cache_stall), 32'd1);
    redirect = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Streaming with decoder always ready.
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1);

    // Backpressure fills the queue, then drains in order.
    step(1, 32'h0, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
    check_eq("full_addr", addr, 32'h10);
    check_eq("full_stall", 32'(pc_cache_stall), 32'd1);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 1);

    // Invalid cache word at 0x20 halts; redirect to 0x04 resumes.
    step(1, 32'h10, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0);
    check_eq("halt_addr", addr, 32'h20);
    check_eq("halt_stall", 32'(pc_cache_stall), 32'd1);
    step(1, 32'h04, 1, 1);
    step(0, 0, 1, 1);
    check_eq("resume_pc", dec_pc, 32'h04);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1);

    // Redirect with three entries queued, misaligned target.
    step(1, 32'h100, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    step(1, 32'h43, 1, 1);
    check_eq("flush_addr", addr, 32'h40);
    check_eq("flush_valid", 32'(dec_valid), 32'd0);
    step(0, 0, 1, 1);
    check_eq("flush_dec_pc", dec_pc, 32'h40);

    // PC wrap at the top of the address space.
    step(1, 32'hFFFF_FFFC, 1, 1);
    step(0, 0, 1, 1);
    check_eq("wrap_addr", addr, 32'h0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1);

    // Held redirect re-applies every cycle.
    step(1, 32'h200, 1, 1);
    step(1, 32'h300, 1, 1);
    step(1, 32'h400, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 99) < 5), $urandom, ($urandom_range(0, 99) < 70),
           ($urandom_range(0, 99) < 92));
    end

    // Asynchronous reset mid-burst clears the queue before any edge.
    step(1, 32'h80, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    redirect = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_valid", 32'(dec_valid), 32'd0);
    check_eq("arst_ce", 32'(ce), 32'd0);
    check_eq("arst_addr", addr, 32'd0);
    check_eq("arst_dec_pc", dec_pc, 32'd0);
    m_q.delete();
    m_pc   = '0;
    m_halt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step(0, 0, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
